// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage. Owns PCF and the IF/ID register, issues
//            one instruction-memory request at a time over a valid/ready
//            channel, buffers a response that lands during a decode stall,
//            drops responses made stale by a redirect, and loads bubbles into
//            IF/ID when memory is slow.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            bubbleD
);

  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  // REQ: may issue a request; WAIT: one request outstanding;
  // FULL: response captured in r_buf_q while decode is stalled.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_pc_q;
  logic [31:0]     r_buf_q;
  logic            r_discard_q;

  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc_plus4_d;
  logic            r_valid_d;
  logic            r_bubble_d;

  logic            w_req_valid;
  logic            w_hs;
  logic            w_deliver_ok;
  logic            w_rsp_good;
  logic            w_deliver;
  logic [31:0]     w_deliver_instr;

  // A redirect or a stalled PC suppresses issue; rst gates the request so a
  // reset cycle never starts a transaction.
  assign w_req_valid     = (r_state == S_REQ) & ~stallF & ~PCSrcE & ~rst;
  assign w_hs            = w_req_valid & imem_req_ready;
  assign w_deliver_ok    = ~stallD & ~flushD & ~PCSrcE;
  assign w_rsp_good      = (r_state == S_WAIT) & imem_rsp_valid & ~r_discard_q;
  assign w_deliver       = (w_rsp_good | (r_state == S_FULL)) & w_deliver_ok;
  assign w_deliver_instr = (r_state == S_FULL) ? r_buf_q : imem_rsp_data;

  assign imem_req_valid  = w_req_valid;
  assign imem_req_addr   = r_pcf;

  // Fetch control: PC update, request tracking, stale-response and buffer handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pcf       <= RESET_PC;
      r_pc_q      <= '0;
      r_buf_q     <= NOP_INSTR;
      r_discard_q <= 1'b0;
    end else begin
      if (PCSrcE) begin
        r_pcf <= PCTargetE;
      end else if (w_hs) begin
        r_pcf <= r_pcf + c_pc_step;
      end

      case (r_state)
        S_REQ: begin
          if (w_hs) begin
            r_pc_q      <= r_pcf;
            r_discard_q <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            // Every response ends the transaction; only a live one that
            // meets a decode stall (and no redirect) is kept.
            r_discard_q <= 1'b0;
            if (!r_discard_q && !w_deliver_ok && stallD && !PCSrcE) begin
              r_buf_q <= imem_rsp_data;
              r_state <= S_FULL;
            end else begin
              r_state <= S_REQ;
            end
          end else if (PCSrcE) begin
            // Response still in flight belongs to the old path.
            r_discard_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (!stallD || PCSrcE) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // IF/ID register: flush beats stall; no delivery means a starvation bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= c_pc_step;
      r_valid_d    <= 1'b0;
      r_bubble_d   <= 1'b0;
    end else if (flushD) begin
      r_instr_d    <= NOP_INSTR;
      r_valid_d    <= 1'b0;
      r_bubble_d   <= 1'b0;
    end else if (stallD) begin
      r_instr_d    <= r_instr_d;
    end else if (w_deliver) begin
      r_instr_d    <= w_deliver_instr;
      r_pc_d       <= r_pc_q;
      r_pc_plus4_d <= r_pc_q + c_pc_step;
      r_valid_d    <= 1'b1;
      r_bubble_d   <= 1'b0;
    end else begin
      r_instr_d    <= NOP_INSTR;
      r_valid_d    <= 1'b0;
      r_bubble_d   <= 1'b1;
    end
  end

  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc_plus4_d;
  assign ValidD   = r_valid_d;
  assign bubbleD  = r_bubble_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit. A per-cycle vector table
//            covers reset, zero-wait fetch, decode stall with buffering,
//            redirect of an in-flight fetch and stall+flush; hand-written
//            sequences cover a slow request channel, PC wrap and reset while
//            waiting. A memory model returns data = address, and a queue
//            scoreboard holds the expected IF/ID contents of each fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stallF, stallD, flushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, bubbleD;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model state
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          cnt = 0;
  int          mem_delay = 0;

  // scoreboard: address of each accepted fetch still expected in IF/ID
  logic [31:0] sb[$];

  typedef struct {
    logic        rst, sf, sd, fd, pc;
    logic [31:0] tgt;
    logic        rdy;
    int          dly;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_v, e_b;
    logic [31:0] e_instr, e_pcd;
  } row_t;

  row_t rows[20];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stallF         (stallF),
    .stallD         (stallD),
    .flushD         (flushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD),
    .bubbleD        (bubbleD)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic r, sf, sd, fd, pc, input logic [31:0] tgt, input logic rdy);
    rst = r; stallF = sf; stallD = sd; flushD = fd; PCSrcE = pc;
    PCTargetE = tgt; imem_req_ready = rdy;
  endtask

  // One clock: capture the pre-edge handshake, advance memory, run scoreboard.
  task automatic tick();
    logic        hs, r_s, pc_s, sd_s, fd_s;
    logic [31:0] ha, e;
    hs = imem_req_valid & imem_req_ready; ha = imem_req_addr;
    r_s = rst; pc_s = PCSrcE; sd_s = stallD; fd_s = flushD;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (r_s) pend = 1'b0;
    else begin
      if (hs) begin pend = 1'b1; paddr = ha; cnt = mem_delay; end
      if (pend) begin
        if (cnt == 0) begin imem_rsp_valid = 1'b1; imem_rsp_data = paddr; pend = 1'b0; end
        else cnt--;
      end
    end
    if (r_s || pc_s) sb.delete();
    else if (!sd_s && !fd_s && ValidD) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got delivery of %h at PCD %h, expected none", InstrD, PCD);
      end else begin
        e = sb.pop_front();
        check("sb_instr", InstrD, e);
        check("sb_pcd", PCD, e);
        check("sb_pcplus4", PCPlus4D, e + 32'd4);
      end
    end
    if (hs && !r_s) sb.push_back(ha);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 1);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    //          rst sf sd fd pc tgt       rdy dly  rv addr      v  b  instr     pcd
    rows[0]  = '{1, 0, 0, 0, 0, 32'h0,    1, 0,   0, 32'h0,    0, 0, NOP,      32'h0};
    rows[1]  = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   1, 32'h0,    0, 1, NOP,      32'h0};
    rows[2]  = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   0, 32'h0,    1, 0, 32'h0,    32'h0};
    rows[3]  = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   1, 32'h4,    0, 1, NOP,      32'h0};
    rows[4]  = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   0, 32'h0,    1, 0, 32'h4,    32'h4};
    rows[5]  = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   1, 32'h8,    0, 1, NOP,      32'h4};
    rows[6]  = '{0, 1, 1, 0, 0, 32'h0,    1, 0,   0, 32'h0,    0, 1, NOP,      32'h4};
    rows[7]  = '{0, 1, 1, 0, 0, 32'h0,    1, 0,   0, 32'h0,    0, 1, NOP,      32'h4};
    rows[8]  = '{0, 1, 1, 0, 0, 32'h0,    1, 0,   0, 32'h0,    0, 1, NOP,      32'h4};
    rows[9]  = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   0, 32'h0,    1, 0, 32'h8,    32'h8};
    rows[10] = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   1, 32'hC,    0, 1, NOP,      32'h8};
    rows[11] = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   0, 32'h0,    1, 0, 32'hC,    32'hC};
    rows[12] = '{0, 0, 0, 0, 0, 32'h0,    1, 1,   1, 32'h10,   0, 1, NOP,      32'hC};
    rows[13] = '{0, 0, 0, 1, 1, 32'h100,  1, 1,   0, 32'h0,    0, 0, NOP,      32'hC};
    rows[14] = '{0, 0, 0, 0, 0, 32'h0,    1, 1,   0, 32'h0,    0, 1, NOP,      32'hC};
    rows[15] = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   1, 32'h100,  0, 1, NOP,      32'hC};
    rows[16] = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   0, 32'h0,    1, 0, 32'h100,  32'h100};
    rows[17] = '{0, 1, 1, 1, 1, 32'h200,  1, 0,   0, 32'h0,    0, 0, NOP,      32'h100};
    rows[18] = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   1, 32'h200,  0, 1, NOP,      32'h100};
    rows[19] = '{0, 0, 0, 0, 0, 32'h0,    1, 0,   0, 32'h0,    1, 0, 32'h200,  32'h200};

    for (int i = 0; i < 20; i++) begin
      drive(rows[i].rst, rows[i].sf, rows[i].sd, rows[i].fd, rows[i].pc, rows[i].tgt, rows[i].rdy);
      mem_delay = rows[i].dly;
      #1;
      check($sformatf("row%0d_req_valid", i), 32'(imem_req_valid), 32'(rows[i].e_rv));
      if (rows[i].e_rv) check($sformatf("row%0d_req_addr", i), imem_req_addr, rows[i].e_addr);
      tick();
      check($sformatf("row%0d_validD", i), 32'(ValidD), 32'(rows[i].e_v));
      check($sformatf("row%0d_bubbleD", i), 32'(bubbleD), 32'(rows[i].e_b));
      check($sformatf("row%0d_instrD", i), InstrD, rows[i].e_instr);
      check($sformatf("row%0d_pcd", i), PCD, rows[i].e_pcd);
      if (i == 0) check("reset_pcplus4", PCPlus4D, 32'h4);
    end

    // Request channel back-pressured for 5 cycles: request held, PCF frozen.
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check($sformatf("slow%0d_req_valid", k), 32'(imem_req_valid), 32'd1);
      check($sformatf("slow%0d_req_addr", k), imem_req_addr, 32'h204);
      tick();
      check($sformatf("slow%0d_bubbleD", k), 32'(bubbleD), 32'd1);
      check($sformatf("slow%0d_validD", k), 32'(ValidD), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("slow_release_addr", imem_req_addr, 32'h204);
    tick();
    tick();
    check("slow_deliver_validD", 32'(ValidD), 32'd1);

    // Redirect to the top word, then the fetch after it wraps to zero.
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    #1;
    check("redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("top_pcd", PCD, 32'hFFFF_FFFC);
    check("top_pcplus4_wrap", PCPlus4D, 32'h0);
    mem_delay = 3;
    #1;
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_req_addr", imem_req_addr, 32'h0);
    tick();
    check("wrap_wait_req_valid", 32'(imem_req_valid), 32'd0);

    // Reset while the wrapped request is outstanding.
    drive(1, 0, 0, 0, 0, 0, 1);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    check("rst_validD", 32'(ValidD), 32'd0);
    check("rst_bubbleD", 32'(bubbleD), 32'd0);
    check("rst_instrD", InstrD, NOP);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pcplus4", PCPlus4D, 32'h4);
    drive(0, 0, 0, 0, 0, 0, 1);
    mem_delay = 0;
    #1;
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, 32'h0);
    tick();
    tick();
    check("post_rst_validD", 32'(ValidD), 32'd1);
    check("post_rst_pcd", PCD, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
